// File: rtl/priv_intr_arbiter.sv
// priv_intr_arbiter: parametrised interrupt pending/arbitration engine.
// Latches per-source pending bits, qualifies them by enable, delegation and
// privilege, picks one M- or S-targeted winner and holds a trap request to
// the pipeline controller until the pipe is clear.
// Optional feature macro: PRIV_INTR_EDGE_EN (per-source edge mode, software
// clear and auto-clear on take). Without it every source is level-sensitive.
module priv_intr_arbiter #(
  parameter int NUM_SRC = 16,
  parameter int CAUSE_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_edge_i,
  input  logic [NUM_SRC-1:0] clear_i,
  input  logic [NUM_SRC-1:0] mie_i,
  input  logic [NUM_SRC-1:0] mideleg_i,
  input  logic               mstatus_mie_i,
  input  logic               mstatus_sie_i,
  input  logic [1:0]         priv_i,
  input  logic               pipe_clear_i,
  input  logic               ex_mem_stall_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               intr_o,
  output logic               intr_to_s_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic               take_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_SRC-1:0]   r_pending, w_pending_nxt;
  logic [CAUSE_W-1:0]   r_cause, w_cause_nxt;
  logic                 r_to_s, w_to_s_nxt;

  logic                 w_m_en, w_s_en, w_any_m, w_any;
  logic [NUM_SRC-1:0]   w_elig_m, w_elig_s, w_elig;
  logic [CAUSE_W-1:0]   w_win_idx;
  logic                 w_win_s;
  logic                 w_lock_elig;

  // Privilege gating: M targets are masked only in M-mode with MIE clear;
  // S targets are taken from U always, from S with SIE, never from M.
  assign w_m_en   = (priv_i != 2'd3) | mstatus_mie_i;
  assign w_s_en   = (priv_i == 2'd0) | ((priv_i == 2'd1) & mstatus_sie_i);
  assign w_elig_m = r_pending & mie_i & ~mideleg_i & {NUM_SRC{w_m_en}};
  assign w_elig_s = r_pending & mie_i &  mideleg_i & {NUM_SRC{w_s_en}};
  assign w_elig   = w_elig_m | w_elig_s;
  assign w_any_m  = |w_elig_m;
  assign w_any    = |w_elig;

  // Winner: any M target beats every S target; highest index within a target
  always_comb begin
    w_win_idx = '0;
    w_win_s   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_any_m ? w_elig_m[i] : w_elig_s[i]) begin
        w_win_idx = CAUSE_W'(i);
        w_win_s   = ~w_any_m;
      end
    end
  end

  // Is the locked source still eligible (used to withdraw a stale request)
  always_comb begin
    w_lock_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_cause == CAUSE_W'(i)) w_lock_elig = w_elig[i];
    end
  end

`ifdef PRIV_INTR_EDGE_EN
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] w_rise, w_ack_sel, w_clr;

  // One-hot of the source being taken this cycle, for edge auto-clear
  always_comb begin
    w_ack_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_ack_sel[i] = (r_state == ST_ACK) && (r_cause == CAUSE_W'(i));
    end
  end

  assign w_rise = src_i & ~r_src_q;
  assign w_clr  = clear_i | w_ack_sel;
  // Set dominates clear for edge sources; level sources just follow src_i
  assign w_pending_nxt = (src_edge_i & (w_rise | (r_pending & ~w_clr)))
                       | (~src_edge_i & src_i);

  // Edge-detect history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_src_q <= '0;
    else     r_src_q <= src_i;
  end
`else
  logic w_unused_edge;
  assign w_unused_edge = ^{src_edge_i, clear_i};
  assign w_pending_nxt = src_i;
`endif

  // Pending register (the mip view)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  // Next-state: lock winner in IDLE, hold or withdraw in REQ, pulse in ACK
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_to_s_nxt  = r_to_s;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_REQ;
          w_cause_nxt = w_win_idx;
          w_to_s_nxt  = w_win_s;
        end
      end
      ST_REQ: begin
        if (!w_lock_elig)                        w_state_nxt = ST_IDLE;
        else if (pipe_clear_i && !ex_mem_stall_i) w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and locked request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cause <= '0;
      r_to_s  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_to_s  <= w_to_s_nxt;
    end
  end

  assign pending_o   = r_pending;
  assign intr_o      = (r_state == ST_REQ);
  assign take_o      = (r_state == ST_ACK);
  assign cause_o     = r_cause;
  assign intr_to_s_o = r_to_s;

endmodule

// File: tb/tb_priv_intr_arbiter.sv
// Self-checking bench for priv_intr_arbiter (NUM_SRC=16): directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_priv_intr_arbiter;
  localparam int N  = 16;
  localparam int CW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  src_i, src_edge_i, clear_i, mie_i, mideleg_i;
  logic          mstatus_mie_i, mstatus_sie_i;
  logic [1:0]    priv_i;
  logic          pipe_clear_i, ex_mem_stall_i;
  logic [N-1:0]  pending_o;
  logic          intr_o, intr_to_s_o, take_o;
  logic [CW-1:0] cause_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: phase 0 = idle, 1 = requesting, 2 = taking
  logic [N-1:0] m_pend, m_prev;
  int           m_phase;
  int           m_cause;
  logic         m_tos;
  logic         prev_take;

  always #5 CLK = ~CLK;

  priv_intr_arbiter #(.NUM_SRC(N), .CAUSE_W(CW)) dut (
    .CLK(CLK), .RST(RST), .src_i(src_i), .src_edge_i(src_edge_i),
    .clear_i(clear_i), .mie_i(mie_i), .mideleg_i(mideleg_i),
    .mstatus_mie_i(mstatus_mie_i), .mstatus_sie_i(mstatus_sie_i),
    .priv_i(priv_i), .pipe_clear_i(pipe_clear_i), .ex_mem_stall_i(ex_mem_stall_i),
    .pending_o(pending_o), .intr_o(intr_o), .intr_to_s_o(intr_to_s_o),
    .cause_o(cause_o), .take_o(take_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Can source i be trapped right now? Returns 0 none, 1 S target, 2 M target
  function automatic int target_of(input int i);
    if (!(m_pend[i] && mie_i[i])) return 0;
    if (!mideleg_i[i]) return (priv_i != 3 || mstatus_mie_i) ? 2 : 0;
    if (priv_i == 0 || (priv_i == 1 && mstatus_sie_i)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_phase = 0; m_cause = 0; m_tos = 1'b0;
    prev_take = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int best, score, nphase;
    logic [N-1:0] npend;
    best = -1;
    for (int i = 0; i < N; i++) begin
      score = (target_of(i) == 2) ? 100 + i : (target_of(i) == 1) ? i : -1;
      if (score > best) best = score;
    end
    nphase = m_phase;
    if (m_phase == 0) begin
      if (best >= 0) begin
        nphase  = 1;
        m_cause = best % 100;
        m_tos   = (best < 100);
      end
    end else if (m_phase == 1) begin
      if (target_of(m_cause) == 0) nphase = 0;
      else if (pipe_clear_i && !ex_mem_stall_i) nphase = 2;
    end else nphase = 0;
`ifdef PRIV_INTR_EDGE_EN
    for (int i = 0; i < N; i++) begin
      if (!src_edge_i[i]) npend[i] = src_i[i];
      else if (src_i[i] && !m_prev[i]) npend[i] = 1'b1;
      else if (clear_i[i] || (m_phase == 2 && m_cause == i)) npend[i] = 1'b0;
      else npend[i] = m_pend[i];
    end
`else
    npend = src_i;
`endif
    m_prev  = src_i;
    m_pend  = npend;
    m_phase = nphase;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_pending"}, pending_o, m_pend);
    chk({tag, "_intr"}, intr_o, (m_phase == 1));
    chk({tag, "_take"}, take_o, (m_phase == 2));
    chk({tag, "_cause"}, cause_o, m_cause);
    chk({tag, "_to_s"}, intr_to_s_o, m_tos);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge CLK); #1;
    chk_all(tag);
    chk({tag, "_take_spacing"}, take_o & prev_take, 0);
    prev_take = take_o;
  endtask

  task automatic do_reset();
    RST = 1'b1; #1;
    model_reset();
    chk_all("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic idle_inputs();
    src_i = '0; src_edge_i = '0; clear_i = '0; mie_i = '1; mideleg_i = '0;
    mstatus_mie_i = 1'b0; mstatus_sie_i = 1'b0; priv_i = 2'd0;
    pipe_clear_i = 1'b1; ex_mem_stall_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Basic M trap on source 7
    src_i = N'(1 << 7);
    tick("m1");  chk("m1_pend7", pending_o, 16'h0080); chk("m1_nointr", intr_o, 0);
    tick("m2");  chk("m2_intr", intr_o, 1); chk("m2_cause", cause_o, 7); chk("m2_tos", intr_to_s_o, 0);
    tick("m3");  chk("m3_take", take_o, 1); chk("m3_intr", intr_o, 0);
    src_i = '0;
    tick("m4");  chk("m4_take", take_o, 0);
    tick("m5");  chk("m5_take", take_o, 0); chk("m5_intr", intr_o, 0);

    // Priority: M beats M lower index
    idle_inputs(); do_reset();
    pipe_clear_i = 1'b0; src_i = 16'h0808;
    tick("p1"); tick("p2"); chk("p2_cause", cause_o, 11); chk("p2_tos", intr_to_s_o, 0);

    // Priority: M target beats higher-index S target, then S after M clears
    idle_inputs(); do_reset();
    pipe_clear_i = 1'b0; mideleg_i = 16'h0800; src_i = 16'h0808;
    tick("q1"); tick("q2"); chk("q2_cause", cause_o, 3); chk("q2_tos", intr_to_s_o, 0);
    src_i = 16'h0800;
    tick("q3"); chk("q3_intr", intr_o, 1);
    tick("q4"); chk("q4_withdraw", intr_o, 0);
    tick("q5"); chk("q5_cause", cause_o, 11); chk("q5_tos", intr_to_s_o, 1); chk("q5_intr", intr_o, 1);

    // Stall hold on delegated source 5 from S-mode
    idle_inputs(); do_reset();
    priv_i = 2'd1; mstatus_sie_i = 1'b1; mideleg_i = N'(1 << 5); src_i = N'(1 << 5);
    ex_mem_stall_i = 1'b1;
    tick("s1"); tick("s2");
    for (int k = 0; k < 3; k++) begin
      tick("s_hold"); chk("s_hold_intr", intr_o, 1); chk("s_hold_cause", cause_o, 5);
      chk("s_hold_notake", take_o, 0);
    end
    ex_mem_stall_i = 1'b0;
    tick("s3"); chk("s3_take", take_o, 1);

    // Withdraw of level source 2
    idle_inputs(); do_reset();
    pipe_clear_i = 1'b0; src_i = N'(1 << 2);
    tick("w1"); tick("w2"); chk("w2_intr", intr_o, 1); chk("w2_cause", cause_o, 2);
    src_i = '0;
    tick("w3"); tick("w4"); chk("w4_intr", intr_o, 0); chk("w4_take", take_o, 0);
    tick("w5"); chk("w5_take", take_o, 0);

    // Reset while requesting, then re-request
    src_i = N'(1 << 2);
    tick("r1"); tick("r2"); chk("r2_intr", intr_o, 1);
    #2 RST = 1'b1; #1;
    model_reset();
    chk("r_async_intr", intr_o, 0); chk("r_async_pend", pending_o, 0);
    chk("r_async_take", take_o, 0); chk("r_async_cause", cause_o, 0);
    @(posedge CLK); #1; RST = 1'b0;
    tick("r3"); chk("r3_pend", pending_o, 16'h0004);
    tick("r4"); chk("r4_intr", intr_o, 1);

`ifdef PRIV_INTR_EDGE_EN
    // Edge source 9 latched until taken; set beats clear on source 4
    idle_inputs(); do_reset();
    src_edge_i = 16'h0210; pipe_clear_i = 1'b0; src_i = N'(1 << 9);
    tick("e1"); chk("e1_pend9", pending_o[9], 1);
    src_i = '0;
    tick("e2"); chk("e2_pend9", pending_o[9], 1); chk("e2_intr", intr_o, 1);
    tick("e3"); chk("e3_pend9", pending_o[9], 1);
    pipe_clear_i = 1'b1;
    tick("e4"); chk("e4_take", take_o, 1);
    tick("e5"); chk("e5_pend9", pending_o[9], 0);
    pipe_clear_i = 1'b0; src_i = N'(1 << 4); clear_i = N'(1 << 4);
    tick("e6"); chk("e6_pend4", pending_o[4], 1);
    clear_i = '0;
`endif

    // Randomized traffic against the model
    idle_inputs(); do_reset();
    src_edge_i = N'($urandom());
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) src_i = N'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        mie_i = N'($urandom()); mideleg_i = N'($urandom());
        priv_i = 2'($urandom_range(0, 3));
        mstatus_mie_i = 1'($urandom()); mstatus_sie_i = 1'($urandom());
      end
      clear_i        = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
      pipe_clear_i   = ($urandom_range(0, 3) != 0);
      ex_mem_stall_i = ($urandom_range(0, 3) == 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
